// File: rtl/warpv_l15_pkg.sv
// Shared types and constants for the WARP-V <-> OpenPiton L1.5 transducer slice:
// arbiter state encoding plus message constants lifted out of the transducer.
package warpv_l15_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2,
      ST_GAP   = 2'd3
   } arb_state_e;

   localparam logic [2:0] MSG_DATA_SIZE_0B  = 3'b000;
   localparam logic [2:0] MSG_DATA_SIZE_1B  = 3'b001;
   localparam logic [2:0] MSG_DATA_SIZE_2B  = 3'b010;
   localparam logic [2:0] MSG_DATA_SIZE_4B  = 3'b011;
   localparam logic [2:0] MSG_DATA_SIZE_8B  = 3'b100;
   localparam logic [2:0] MSG_DATA_SIZE_16B = 3'b101;
   localparam logic [2:0] MSG_DATA_SIZE_32B = 3'b110;
   localparam logic [2:0] MSG_DATA_SIZE_64B = 3'b111;

   localparam int L15_AMO_OP_WIDTH = 4;
   localparam int PHY_ADDR_WIDTH   = 40;

endpackage

// File: rtl/warpv_rr_arb2.sv
// Two-requester round-robin grant: when both request, the port that did not
// win last time is chosen. Purely combinational.
module warpv_rr_arb2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic gnt_valid,
   output logic gnt_port
);

   always_comb begin
      gnt_valid = valid0 | valid1;
      gnt_port  = (valid0 & valid1) ? ~last_grant : valid1;
   end

endmodule

// File: rtl/warpv_l15_port_arbiter.sv
// Shares the single transducer memory port between instruction fetch (port 0)
// and load/store (port 1); one outstanding request, round-robin, watchdog.
module warpv_l15_port_arbiter
   import warpv_l15_pkg::*;
#(
   parameter int GAP_CYCLES     = 1,
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int CNT_W          = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic [31:0] req0_addr,
   input  logic [3:0]  req0_wstrb,
   input  logic [31:0] req0_wdata,
   output logic        req0_ready,
   output logic [31:0] req0_rdata,
   input  logic        req1_valid,
   input  logic [31:0] req1_addr,
   input  logic [3:0]  req1_wstrb,
   input  logic [31:0] req1_wdata,
   output logic        req1_ready,
   output logic [31:0] req1_rdata,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        timeout_err,
   input  logic        err_clr,
   output logic [1:0]  dbg_state
);

   // Handshake: reqN_valid is held until a one-cycle reqN_ready strobe;
   // mem_valid is held with stable fields until mem_ready is seen in ISSUE.
   arb_state_e        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              grant_q, grant_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              mem_valid_q, mem_valid_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [3:0]        mem_wstrb_q, mem_wstrb_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              req0_ready_q, req0_ready_d;
   logic              req1_ready_q, req1_ready_d;
   logic [31:0]       req0_rdata_q, req0_rdata_d;
   logic [31:0]       req1_rdata_q, req1_rdata_d;
   logic              timeout_err_q, timeout_err_d;
   logic              arb_valid, arb_port;
   logic              resp_fire, timeout_set, expire;
   logic [31:0]       resp_data;

   warpv_rr_arb2 u_arb (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .last_grant (last_grant_q),
      .gnt_valid  (arb_valid),
      .gnt_port   (arb_port)
   );

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      grant_d       = grant_q;
      cnt_d         = cnt_q;
      mem_valid_d   = mem_valid_q;
      mem_addr_d    = mem_addr_q;
      mem_wstrb_d   = mem_wstrb_q;
      mem_wdata_d   = mem_wdata_q;
      req0_ready_d  = 1'b0;
      req1_ready_d  = 1'b0;
      req0_rdata_d  = req0_rdata_q;
      req1_rdata_d  = req1_rdata_q;
      resp_fire     = 1'b0;
      resp_data     = 32'd0;
      timeout_set   = 1'b0;
      cnt_inc       = cnt_q + CNT_W'(1);
      expire        = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               grant_d      = arb_port;
               last_grant_d = arb_port;
               mem_addr_d   = arb_port ? req1_addr  : req0_addr;
               mem_wstrb_d  = arb_port ? req1_wstrb : req0_wstrb;
               mem_wdata_d  = arb_port ? req1_wdata : req0_wdata;
               mem_valid_d  = 1'b1;
               cnt_d        = '0;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d = cnt_inc;
            // A response in the expiry cycle is real data, so it beats the watchdog.
            if (mem_ready) begin
               resp_fire = 1'b1;
               resp_data = mem_rdata;
            end else if (expire) begin
               resp_fire   = 1'b1;
               timeout_set = 1'b1;
            end
            if (resp_fire) begin
               mem_valid_d = 1'b0;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            cnt_d   = '0;
            state_d = ST_GAP;
         end
         ST_GAP: begin
            if (cnt_inc == CNT_W'(GAP_CYCLES)) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (resp_fire) begin
         if (grant_q) begin
            req1_ready_d = 1'b1;
            req1_rdata_d = resp_data;
         end else begin
            req0_ready_d = 1'b1;
            req0_rdata_d = resp_data;
         end
      end

      timeout_err_d = timeout_err_q;
      if (timeout_set)  timeout_err_d = 1'b1;
      else if (err_clr) timeout_err_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         last_grant_q  <= 1'b1;
         grant_q       <= 1'b0;
         cnt_q         <= '0;
         mem_valid_q   <= 1'b0;
         mem_addr_q    <= 32'd0;
         mem_wstrb_q   <= 4'd0;
         mem_wdata_q   <= 32'd0;
         req0_ready_q  <= 1'b0;
         req1_ready_q  <= 1'b0;
         req0_rdata_q  <= 32'd0;
         req1_rdata_q  <= 32'd0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         grant_q       <= grant_d;
         cnt_q         <= cnt_d;
         mem_valid_q   <= mem_valid_d;
         mem_addr_q    <= mem_addr_d;
         mem_wstrb_q   <= mem_wstrb_d;
         mem_wdata_q   <= mem_wdata_d;
         req0_ready_q  <= req0_ready_d;
         req1_ready_q  <= req1_ready_d;
         req0_rdata_q  <= req0_rdata_d;
         req1_rdata_q  <= req1_rdata_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign mem_valid   = mem_valid_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wstrb   = mem_wstrb_q;
   assign mem_wdata   = mem_wdata_q;
   assign req0_ready  = req0_ready_q;
   assign req1_ready  = req1_ready_q;
   assign req0_rdata  = req0_rdata_q;
   assign req1_rdata  = req1_rdata_q;
   assign timeout_err = timeout_err_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_warpv_l15_port_arbiter.sv
// Directed bench for the L1.5 port arbiter: load, contention, fairness,
// watchdog expiry, simultaneous expiry and reset mid-transaction.
module tb_warpv_l15_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
   logic [3:0]  req0_wstrb, req1_wstrb;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_rdata, req1_rdata;
   logic        mem_valid, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        timeout_err, err_clr;
   logic [1:0]  dbg_state;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   warpv_l15_port_arbiter #(
      .GAP_CYCLES     (1),
      .TIMEOUT_CYCLES (8),
      .CNT_W          (10)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_addr   (req0_addr),
      .req0_wstrb  (req0_wstrb),
      .req0_wdata  (req0_wdata),
      .req0_ready  (req0_ready),
      .req0_rdata  (req0_rdata),
      .req1_valid  (req1_valid),
      .req1_addr   (req1_addr),
      .req1_wstrb  (req1_wstrb),
      .req1_wdata  (req1_wdata),
      .req1_ready  (req1_ready),
      .req1_rdata  (req1_rdata),
      .mem_valid   (mem_valid),
      .mem_addr    (mem_addr),
      .mem_wstrb   (mem_wstrb),
      .mem_wdata   (mem_wdata),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .timeout_err (timeout_err),
      .err_clr     (err_clr),
      .dbg_state   (dbg_state)
   );

   // clock/reset
   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for mem_valid; returns number of low negedges seen.
   task automatic wait_mem_valid(input string tag, output int low_cycles);
      low_cycles = 0;
      while (!mem_valid && low_cycles < 40) begin
         step();
         low_cycles++;
      end
      if (!mem_valid) chk({tag, "_mem_valid_timeout"}, {31'd0, mem_valid}, 32'd1);
   endtask

   // Wait for issue, answer with rd; returns at the RESP negedge.
   task automatic serve(input string tag, input logic [31:0] rd,
                        output logic [31:0] addr, output logic [1:0] rdy,
                        output int low_cycles);
      wait_mem_valid(tag, low_cycles);
      addr      = mem_addr;
      mem_ready = 1'b1;
      mem_rdata = rd;
      step();
      mem_ready = 1'b0;
      mem_rdata = 32'd0;
      rdy       = {req1_ready, req0_ready};
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  r;
      int          n;

      rst_n = 1'b0; req0_valid = 0; req1_valid = 0;
      req0_addr = 0; req1_addr = 0; req0_wdata = 0; req1_wdata = 0;
      req0_wstrb = 0; req1_wstrb = 0; mem_ready = 0; mem_rdata = 0; err_clr = 0;
      step(); step();
      chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
      chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
      chk("rst_state", {30'd0, dbg_state}, 32'd0);
      chk("rst_rdata0", req0_rdata, 32'd0);

      // Single load on port 0
      rst_n = 1'b1;
      req0_valid = 1; req0_addr = 32'h0000_1000; req0_wstrb = 0;
      step();
      chk("load_mem_valid", {31'd0, mem_valid}, 32'd1);
      chk("load_mem_addr", mem_addr, 32'h0000_1000);
      chk("load_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
      mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
      step();
      mem_ready = 0; mem_rdata = 0;
      chk("load_ready0", {31'd0, req0_ready}, 32'd1);
      chk("load_rdata0", req0_rdata, 32'hDEAD_BEEF);
      chk("load_ready1", {31'd0, req1_ready}, 32'd0);
      chk("load_mem_valid_low", {31'd0, mem_valid}, 32'd0);
      req0_valid = 0;
      step();
      chk("load_ready0_pulse", {31'd0, req0_ready}, 32'd0);
      chk("load_rdata0_hold", req0_rdata, 32'hDEAD_BEEF);
      step(); step();

      // Contention straight out of reset
      rst_n = 0;
      step();
      req0_valid = 1; req0_addr = 32'h0000_2000; req0_wstrb = 0;
      req1_valid = 1; req1_addr = 32'h0000_3000; req1_wstrb = 4'b0011; req1_wdata = 32'h1234;
      rst_n = 1;
      serve("cont0", 32'h1111_0000, a, r, n);
      chk("cont0_addr", a, 32'h0000_2000);
      chk("cont0_ready", {30'd0, r}, 32'd1);
      req0_valid = 0;
      wait_mem_valid("cont1", n);
      chk("cont_gap_low_cycles", n, 32'd3);
      chk("cont1_addr", mem_addr, 32'h0000_3000);
      chk("cont1_wstrb", {28'd0, mem_wstrb}, 32'h3);
      chk("cont1_wdata", mem_wdata, 32'h1234);
      serve("cont1r", 32'h2222_0000, a, r, n);
      chk("cont1_ready", {30'd0, r}, 32'd2);
      chk("cont1_rdata", req1_rdata, 32'h2222_0000);

      // Fairness: both held for six transactions, last grant was port 1
      req0_addr = 32'h0000_4000; req1_addr = 32'h0000_5000; req1_wstrb = 0;
      req0_valid = 1;
      for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 32'd0 : 32'd1);
      for (int i = 0; i < 6; i++) begin
         logic [31:0] ep;
         ep = exp_q.pop_front();
         serve("fair", 32'hF000_0000 + i, a, r, n);
         chk($sformatf("fair%0d_addr", i), a, (ep == 0) ? 32'h0000_4000 : 32'h0000_5000);
         chk($sformatf("fair%0d_ready", i), {30'd0, r}, (ep == 0) ? 32'd1 : 32'd2);
      end
      req0_valid = 0; req1_valid = 0;
      chk("fair_rdata0", req0_rdata, 32'hF000_0004);
      chk("fair_rdata1", req1_rdata, 32'hF000_0005);

      // Watchdog expiry on port 1
      req1_valid = 1; req1_addr = 32'h0000_6000;
      wait_mem_valid("to", n);
      n = 0;
      while (mem_valid && n < 20) begin
         step();
         n++;
      end
      chk("to_issue_cycles", n, 32'd8);
      chk("to_ready1", {31'd0, req1_ready}, 32'd1);
      chk("to_rdata1", req1_rdata, 32'd0);
      chk("to_err_set", {31'd0, timeout_err}, 32'd1);
      req1_valid = 0;
      mem_ready = 1; mem_rdata = 32'h0000_0BAD;
      step();
      mem_ready = 0; mem_rdata = 0;
      chk("to_late_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("to_late_rdata", req1_rdata, 32'd0);
      chk("to_err_sticky", {31'd0, timeout_err}, 32'd1);
      err_clr = 1;
      step();
      err_clr = 0;
      chk("to_err_clr", {31'd0, timeout_err}, 32'd0);

      // mem_ready in the expiry cycle wins
      req0_valid = 1; req0_addr = 32'h0000_7000;
      wait_mem_valid("sim", n);
      for (int i = 0; i < 7; i++) step();
      chk("sim_still_issue", {31'd0, mem_valid}, 32'd1);
      mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
      step();
      mem_ready = 0; mem_rdata = 0;
      chk("sim_ready0", {31'd0, req0_ready}, 32'd1);
      chk("sim_rdata0", req0_rdata, 32'hCAFE_F00D);
      chk("sim_no_err", {31'd0, timeout_err}, 32'd0);
      req0_valid = 0;

      // Reset while ISSUE is outstanding on port 1
      req1_valid = 1; req1_addr = 32'h0000_8000;
      wait_mem_valid("rst", n);
      rst_n = 0;
      step();
      chk("rst_mid_mem_valid", {31'd0, mem_valid}, 32'd0);
      chk("rst_mid_state", {30'd0, dbg_state}, 32'd0);
      chk("rst_mid_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      rst_n = 1;
      req0_valid = 1; req0_addr = 32'h0000_9000;
      serve("post_rst", 32'h5A5A_5A5A, a, r, n);
      chk("post_rst_addr", a, 32'h0000_9000);
      chk("post_rst_ready", {30'd0, r}, 32'd1);
      req0_valid = 0; req1_valid = 0;
      step(); step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
